// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO execute unit: op codes, FSM encoding and default width.
package hilo_pkg;

    localparam int HILO_DATA_WIDTH = 32;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MADD  = 3'd3;
    localparam logic [2:0] OP_MSUB  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/shift_add_mult_core.sv
// Iterative unsigned shift-add multiplier, one partial-product step per cycle.
// With HILO_EARLY_TERM_EN defined, last_o also fires once the remaining multiplier bits are zero.
module shift_add_mult_core
    import hilo_pkg::*;
#(
    parameter int DATA_WIDTH = HILO_DATA_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    load_i,
    input  logic                    step_i,
    input  logic [DATA_WIDTH-1:0]   mcand_i,
    input  logic [DATA_WIDTH-1:0]   mplier_i,
    output logic [2*DATA_WIDTH-1:0] product_o,
    output logic                    last_o
);
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_WIDTH - 1);

    logic [PW-1:0]         prod_q, prod_d;
    logic [PW-1:0]         mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        prod_d   = prod_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            prod_d   = '0;
            mcand_d  = {{DATA_WIDTH{1'b0}}, mcand_i};
            mplier_d = mplier_i;
            cnt_d    = '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    // last_o describes the step about to be taken with the current register contents
`ifdef HILO_EARLY_TERM_EN
    assign last_o = (cnt_q == CNT_MAX) || (mplier_q[DATA_WIDTH-1:1] == '0);
`else
    assign last_o = (cnt_q == CNT_MAX);
`endif

    assign product_o = prod_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/hilo_mult_unit.sv
// HI/LO execute unit: owns HI/LO, sequences the multiply core, applies sign and accumulate, raises stall.
// Optional HILO_EARLY_TERM_EN shortens multiplies whose multiplier runs out of set bits early.
module hilo_mult_unit
    import hilo_pkg::*;
#(
    parameter int DATA_WIDTH = HILO_DATA_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [DATA_WIDTH-1:0] OperandA_In,
    input  logic [DATA_WIDTH-1:0] OperandB_In,
    input  logic                  ReadHiLo,
    input  logic                  ReadSel,
    output logic [DATA_WIDTH-1:0] HiLo_Out,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Stall_Out
);
    localparam int PW = 2 * DATA_WIDTH;

    logic [1:0]            state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic                  sign_q, sign_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;

    logic                  op_signed;
    logic                  mul_load;
    logic                  mul_step;
    logic                  mul_last;
    logic [PW-1:0]         mul_product;
    logic signed [PW-1:0]  prod_signed;
    logic signed [PW-1:0]  acc_result;

    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] v,
                                                        input logic is_signed);
        return (is_signed && v[DATA_WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic signed [PW-1:0] apply_sign(input logic [PW-1:0] p, input logic neg);
        return neg ? -$signed(p) : $signed(p);
    endfunction

    assign op_signed = (Op != OP_MULTU);
    assign mul_load  = (state_q == ST_IDLE) && Start && is_mul_op(Op);
    assign mul_step  = (state_q == ST_RUN);

    shift_add_mult_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_core (
        .clk_i    (Clk),
        .rst_ni   (Reset_n),
        .load_i   (mul_load),
        .step_i   (mul_step),
        .mcand_i  (magnitude(OperandA_In, op_signed)),
        .mplier_i (magnitude(OperandB_In, op_signed)),
        .product_o(mul_product),
        .last_o   (mul_last)
    );

    // WRITE stage: sign-correct the magnitude product, then optionally fold into {HI,LO}
    assign prod_signed = apply_sign(mul_product, sign_q);

    always_comb begin
        acc_result = prod_signed;
        case (op_q)
            OP_MADD: acc_result = $signed({hi_q, lo_q}) + prod_signed;
            OP_MSUB: acc_result = $signed({hi_q, lo_q}) - prod_signed;
            default: acc_result = prod_signed;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        sign_d  = sign_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    if (is_mul_op(Op)) begin
                        state_d = ST_RUN;
                        op_d    = Op;
                        sign_d  = op_signed && (OperandA_In[DATA_WIDTH-1] ^ OperandB_In[DATA_WIDTH-1]);
                    end else if (Op == OP_MTHI) begin
                        hi_d = OperandA_In;
                    end else if (Op == OP_MTLO) begin
                        lo_d = OperandA_In;
                    end
                end
            end
            ST_RUN: begin
                if (mul_last) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                {hi_d, lo_d} = acc_result;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_NOP;
            sign_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy      = (state_q == ST_RUN) || (state_q == ST_WRITE);
    assign Done      = (state_q == ST_WRITE);
    assign Stall_Out = Busy && (Start || ReadHiLo);
    assign HiLo_Out  = ReadSel ? hi_q : lo_q;

endmodule
